// File: rtl/bp_be_ptw_responder.sv
// rtl/bp_be_ptw_responder.sv - PTE load responder for the page table walker.
// A small fully associative PTE buffer sits in front of a read-only memory port; flushes force a replay.
module bp_be_ptw_responder #(
  parameter int paddr_width_p       = 40,
  parameter int pte_size_in_bytes_p = 8,
  parameter int buf_els_p           = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     ptw_v_i,
  output logic                     ptw_ready_o,
  input  logic [paddr_width_p-1:0] ptw_addr_i,
  output logic                     ptw_v_o,
  output logic [63:0]              ptw_data_o,
  output logic                     ptw_replay_o,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     mem_v_o,
  input  logic                     mem_ready_i,
  output logic [paddr_width_p-1:0] mem_addr_o,
  input  logic                     mem_v_i,
  input  logic [63:0]              mem_data_i
);

  localparam int lg_pte_lp = $clog2(pte_size_in_bytes_p);
  localparam int tag_w_lp  = paddr_width_p - lg_pte_lp;
  localparam int ptr_w_lp  = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;

  typedef enum logic [2:0] {e_idle, e_hit, e_send, e_wait, e_drain} state_e;

  state_e                state_q, state_d;
  logic [tag_w_lp-1:0]   tag_q, tag_d;
  logic [63:0]           hit_data_q, hit_data_d;
  logic [buf_els_p-1:0]  valid_q, valid_d;
  logic [tag_w_lp-1:0]   buf_tag_q [buf_els_p];
  logic [tag_w_lp-1:0]   buf_tag_d [buf_els_p];
  logic [63:0]           buf_data_q [buf_els_p];
  logic [63:0]           buf_data_d [buf_els_p];
  logic [ptr_w_lp-1:0]   rr_q, rr_d;

  logic [tag_w_lp-1:0]   req_tag;
  logic                  lookup_hit;
  logic [63:0]           lookup_data;
  logic                  accept;
  logic                  unused_addr_parity;

  assign req_tag            = ptw_addr_i[paddr_width_p-1:lg_pte_lp];
  assign unused_addr_parity = ^ptw_addr_i;

  // Reset gates ready so the walker never sees an accept while the block is held in reset.
  assign ptw_ready_o = reset_n_i & (state_q == e_idle) & ~flush_i;
  assign accept      = ptw_v_i & ptw_ready_o;
  assign busy_o      = (state_q != e_idle);
  assign mem_addr_o  = paddr_width_p'(tag_q) << lg_pte_lp;

  // Tags are unique in the buffer, so OR-combining the matching data is safe.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < buf_els_p; i++) begin
      if (valid_q[i] && (buf_tag_q[i] == req_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = lookup_data | buf_data_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    hit_data_d   = hit_data_q;
    valid_d      = flush_i ? '0 : valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    rr_d         = rr_q;
    ptw_v_o      = 1'b0;
    ptw_data_o   = '0;
    ptw_replay_o = 1'b0;
    mem_v_o      = 1'b0;

    case (state_q)
      e_idle: begin
        if (accept) begin
          tag_d = req_tag;
          if (lookup_hit) begin
            hit_data_d = lookup_data;
            state_d    = e_hit;
          end else begin
            state_d = e_send;
          end
        end
      end
      e_hit: begin
        if (flush_i) begin
          ptw_replay_o = 1'b1;
        end else begin
          ptw_v_o    = 1'b1;
          ptw_data_o = hit_data_q;
        end
        state_d = e_idle;
      end
      e_send: begin
        if (flush_i) begin
          ptw_replay_o = 1'b1;
          state_d      = e_idle;
        end else begin
          mem_v_o = 1'b1;
          if (mem_ready_i) state_d = e_wait;
        end
      end
      e_wait: begin
        if (flush_i) begin
          ptw_replay_o = 1'b1;
          state_d      = mem_v_i ? e_idle : e_drain;
        end else if (mem_v_i) begin
          ptw_v_o            = 1'b1;
          ptw_data_o         = mem_data_i;
          valid_d[rr_q]      = 1'b1;
          buf_tag_d[rr_q]    = tag_q;
          buf_data_d[rr_q]   = mem_data_i;
          rr_d               = (rr_q == ptr_w_lp'(buf_els_p - 1)) ? '0 : rr_q + 1'b1;
          state_d            = e_idle;
        end
      end
      e_drain: begin
        if (mem_v_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      tag_q      <= '0;
      hit_data_q <= '0;
      valid_q    <= '0;
      rr_q       <= '0;
      for (int i = 0; i < buf_els_p; i++) begin
        buf_tag_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      hit_data_q <= hit_data_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_bp_be_ptw_responder.sv
// tb/tb_bp_be_ptw_responder.sv - scoreboard bench for bp_be_ptw_responder.
// Stimulus pushes expected responses/replays; a negedge monitor pops and compares them.
module tb_bp_be_ptw_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        ptw_v_i;
  logic        ptw_ready_o;
  logic [39:0] ptw_addr_i;
  logic        ptw_v_o;
  logic [63:0] ptw_data_o;
  logic        ptw_replay_o;
  logic        flush_i;
  logic        busy_o;
  logic        mem_v_o;
  logic        mem_ready_i;
  logic [39:0] mem_addr_o;
  logic        mem_v_i;
  logic [63:0] mem_data_i;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [64:0] qexp [$];

  bp_be_ptw_responder dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .ptw_v_i(ptw_v_i), .ptw_ready_o(ptw_ready_o), .ptw_addr_i(ptw_addr_i),
    .ptw_v_o(ptw_v_o), .ptw_data_o(ptw_data_o), .ptw_replay_o(ptw_replay_o),
    .flush_i(flush_i), .busy_o(busy_o),
    .mem_v_o(mem_v_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_v_i(mem_v_i), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (mem_v_o && mem_ready_i) hs_cnt++;
      if (ptw_v_o && ptw_replay_o) begin
        chk("v_and_replay", {ptw_replay_o, ptw_v_o}, 65'd2);
      end else if (ptw_v_o || ptw_replay_o) begin
        if (qexp.size() == 0) begin
          chk("unexpected_out", {ptw_replay_o, ptw_data_o}, 65'd0);
        end else begin
          chk("response", {ptw_replay_o, ptw_v_o ? ptw_data_o : 64'd0}, qexp.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [39:0] addr);
    int n = 0;
    while (!ptw_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("issue_timeout", 65'(ptw_ready_o), 65'd1);
    ptw_v_i    = 1'b1;
    ptw_addr_i = addr;
    tick();
    ptw_v_i    = 1'b0;
  endtask

  task automatic serve_miss(input string name, input logic [39:0] addr, input logic [63:0] data,
                            input int rdly, input int ddly);
    int hs0;
    hs0 = hs_cnt;
    issue(addr);
    chk({name, "_miss"}, {mem_v_o, mem_addr_o}, {1'b1, addr & ~40'h7});
    repeat (rdly) begin
      tick();
      chk({name, "_stable"}, {mem_v_o, mem_addr_o}, {1'b1, addr & ~40'h7});
    end
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    repeat (ddly - 1) tick();
    qexp.push_back({1'b0, data});
    mem_v_i    = 1'b1;
    mem_data_i = data;
    tick();
    mem_v_i    = 1'b0;
    chk({name, "_handshakes"}, 65'(hs_cnt - hs0), 65'd1);
    chk({name, "_idle"}, 65'(busy_o), 65'd0);
  endtask

  task automatic expect_hit(input string name, input logic [39:0] addr, input logic [63:0] data);
    qexp.push_back({1'b0, data});
    issue(addr);
    chk({name, "_no_mem"}, 65'(mem_v_o), 65'd0);
    tick();
    chk({name, "_done"}, {busy_o, mem_v_o}, 65'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i   = 1'b0;
    ptw_v_i     = 1'b0;
    ptw_addr_i  = '0;
    flush_i     = 1'b0;
    mem_ready_i = 1'b0;
    mem_v_i     = 1'b0;
    mem_data_i  = '0;
    #1;
    chk("reset_outs", {ptw_ready_o, busy_o, mem_v_o, ptw_v_o, ptw_replay_o}, 65'd0);
    #11 reset_n_i = 1'b1;
    tick();
    chk("reset_ready", {ptw_ready_o, busy_o}, 65'b10);

    serve_miss("t1", 40'h8000_1008, 64'h2000_0C01, 0, 3);
    expect_hit("t2", 40'h8000_1008, 64'h2000_0C01);

    // flush with a request in idle: not accepted
    flush_i    = 1'b1;
    ptw_v_i    = 1'b1;
    ptw_addr_i = 40'h8000_1008;
    #1 chk("t3_ready_low", 65'(ptw_ready_o), 65'd0);
    tick();
    flush_i = 1'b0;
    ptw_v_i = 1'b0;
    chk("t3_not_accepted", {busy_o, mem_v_o}, 65'd0);

    serve_miss("t4", 40'h8000_1008, 64'h1111_2222_3333_4444, 5, 2);

    // flush in e_hit turns the response into a replay
    qexp.push_back({1'b1, 64'd0});
    issue(40'h8000_1008);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5_idle", 65'(busy_o), 65'd0);

    // flush in e_wait: replay, then drain until the read returns
    issue(40'h8000_1008);
    chk("t6_miss", 65'(mem_v_o), 65'd1);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    qexp.push_back({1'b1, 64'd0});
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t6_drain_busy", 65'(busy_o), 65'd1);
    tick();
    tick();
    chk("t6_drain_busy2", 65'(busy_o), 65'd1);
    mem_v_i    = 1'b1;
    mem_data_i = 64'hDEAD_BEEF;
    tick();
    mem_v_i = 1'b0;
    chk("t6_drained", 65'(busy_o), 65'd0);
    serve_miss("t7", 40'h8000_1008, 64'h5555, 0, 1);

    // flush in e_send: no memory request issued
    begin
      int hs0;
      hs0 = hs_cnt;
      issue(40'h200);
      chk("t8_send", 65'(mem_v_o), 65'd1);
      qexp.push_back({1'b1, 64'd0});
      flush_i = 1'b1;
      #1 chk("t8_mem_v_forced", 65'(mem_v_o), 65'd0);
      tick();
      flush_i = 1'b0;
      chk("t8_no_hs", {65'(hs_cnt - hs0)}, 65'd0);
      chk("t8_idle", 65'(busy_o), 65'd0);
    end

    // round robin: C evicts A
    serve_miss("rr_a", 40'h100, 64'hAAAA, 0, 2);
    serve_miss("rr_b", 40'h108, 64'hBBBB, 0, 2);
    serve_miss("rr_c", 40'h110, 64'hCCCC, 0, 2);
    expect_hit("rr_b_hit", 40'h108, 64'hBBBB);
    expect_hit("rr_c_hit", 40'h110, 64'hCCCC);
    serve_miss("rr_a_miss", 40'h100, 64'hA0A0, 0, 2);

    // flush with mem_v_i in e_wait: replay wins, no fill
    issue(40'h300);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    qexp.push_back({1'b1, 64'd0});
    flush_i    = 1'b1;
    mem_v_i    = 1'b1;
    mem_data_i = 64'h3333;
    tick();
    flush_i = 1'b0;
    mem_v_i = 1'b0;
    chk("t10_idle", 65'(busy_o), 65'd0);
    serve_miss("t10_refetch", 40'h300, 64'h3030, 0, 2);

    // async reset mid-cycle in e_wait
    issue(40'h400);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    chk("t11_wait", 65'(busy_o), 65'd1);
    #2 reset_n_i = 1'b0;
    #1 chk("t11_reset_outs", {ptw_ready_o, busy_o, mem_v_o, ptw_v_o, ptw_replay_o}, 65'd0);
    #3 reset_n_i = 1'b1;
    #1 chk("t11_after_reset", {ptw_ready_o, busy_o}, 65'b10);
    tick();
    mem_v_i    = 1'b1;
    mem_data_i = 64'h4444;
    tick();
    mem_v_i = 1'b0;
    chk("t11_stray_ignored", 65'(busy_o), 65'd0);
    serve_miss("t11_refetch", 40'h300, 64'h3131, 0, 2);

    tick();
    chk("queue_empty", 65'(qexp.size()), 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_ptw_responder.md
Name: bp_be_ptw_responder

Overview:
- Services page-table-entry load requests issued by the backend page table walker and returns one 64-bit PTE per request.
- Sits between the walker's load request/response interface and a simple read-only memory port toward the cache/memory side.
- Holds a small fully associative PTE buffer, so repeated walks of the upper page-table levels hit locally.
- Supports replay: any request in flight when a flush (sfence/dcache flush) arrives is dropped, and the walker must reissue it.

Parameters:
- paddr_width_p, 40, physical address width.
- pte_size_in_bytes_p, 8, PTE size; the low log2(pte_size_in_bytes_p) address bits are ignored.
- buf_els_p, 2, number of PTE buffer entries, >=1.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- ptw_v_i  in  1  PTE load request valid.
- ptw_ready_o  out  1  responder can accept a request.
- ptw_addr_i  in  paddr_width_p  PTE physical address.
- ptw_v_o  out  1  response valid, single-cycle pulse.
- ptw_data_o  out  64  PTE data, meaningful only while ptw_v_o=1.
- ptw_replay_o  out  1  request dropped, reissue required; single-cycle pulse.
- flush_i  in  1  invalidate buffer and abort any in-flight request.
- busy_o  out  1  state != e_idle.
- mem_v_o  out  1  memory read request valid.
- mem_ready_i  in  1  memory accepts the request (handshake = mem_v_o & mem_ready_i).
- mem_addr_o  out  paddr_width_p  read address, PTE-aligned (low bits zero).
- mem_v_i  in  1  read data valid; always accepted.
- mem_data_i  in  64  read data.

Behaviour:
- Reset, async on reset_n_i low: state e_idle, all buffer valid bits 0, round-robin pointer 0, every output 0 except ptw_ready_o=1 once reset deasserts. Reset mid-operation discards everything; a later mem_v_i for the aborted read is ignored while in e_idle.
- ptw_ready_o = e_idle & ~flush_i. Accept = ptw_v_i & ptw_ready_o. The address is latched on accept. Only one request is outstanding at a time.
- Tag = addr[paddr_width_p-1:lg(pte_size_in_bytes_p)]. Lookup compares all valid entries in the accept cycle.
- States:
  - e_idle: on accept with hit -> e_hit, latching the hit data. On accept with miss -> e_send.
  - e_hit: ptw_v_o=1 with the latched data (latency 1 cycle after accept) -> e_idle. If flush_i: ptw_v_o=0, ptw_replay_o=1 -> e_idle.
  - e_send: mem_v_o=1 with the aligned address. On handshake -> e_wait. If flush_i: mem_v_o forced 0, ptw_replay_o=1 -> e_idle; no memory request issued.
  - e_wait: on mem_v_i, ptw_v_o=1 with ptw_data_o=mem_data_i in the same cycle. The entry at the round-robin pointer is filled, the pointer increments and wraps at buf_els_p-1 -> 0, -> e_idle. If flush_i without mem_v_i: ptw_replay_o=1 -> e_drain. If flush_i with mem_v_i in the same cycle: replay wins, no response, no fill -> e_idle.
  - e_drain: wait for mem_v_i, discard the data, no fill, no response -> e_idle. ptw_replay_o is not repeated.
- flush_i in any state clears all valid bits the following cycle; the round-robin pointer is unchanged.
- flush_i in e_idle: ptw_ready_o=0, so no request is accepted that cycle.
- Filling an address already buffered is impossible, because a miss implies it is absent.
- ptw_v_o and ptw_replay_o are never asserted in the same cycle.

Test Plan:
- Miss then hit:
  - Request 0x8000_1008 in idle.
  - mem_ready_i high and mem_v_i 3 cycles later with data 0x2000_0C01 -> ptw_v_o pulse with that data in the mem_v_i cycle.
  - Repeat the same address -> ptw_v_o one cycle after accept, with mem_v_o never asserted.
- Backpressure: hold mem_ready_i low for 5 cycles -> mem_v_o and mem_addr_o stay stable (0x8000_1008) throughout; exactly one handshake occurs.
- Flush in e_wait:
  - flush_i while waiting -> ptw_replay_o pulse, busy_o stays high until mem_v_i.
  - The discarded data does not fill; re-requesting the same address misses (mem_v_o=1).
- Round-robin eviction (buf_els_p=2):
  - Fill A=0x100, B=0x108, C=0x110 in order -> C evicts A.
  - Request A -> miss; request B -> hit.
- Simultaneous events:
  - flush_i with mem_v_i in e_wait -> ptw_replay_o=1, ptw_v_o=0, no fill.
  - flush_i with ptw_v_i in idle -> ptw_ready_o=0, request not accepted.
- Async reset in e_wait: assert reset_n_i low mid-cycle -> outputs go 0 immediately. After release, a stray mem_v_i is ignored and a new request to a previously buffered address misses.
